// File: rtl/branch_cond_pkg.sv
// Shared definitions for the branch condition unit: condition codes, FSM states,
// flag layout and the HALT flag pattern.
package branch_cond_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned UPD_W  = 3;

  localparam logic [COND_W-1:0] COND_EQ = 4'd0;
  localparam logic [COND_W-1:0] COND_NE = 4'd1;
  localparam logic [COND_W-1:0] COND_CS = 4'd2;
  localparam logic [COND_W-1:0] COND_CC = 4'd3;
  localparam logic [COND_W-1:0] COND_MI = 4'd4;
  localparam logic [COND_W-1:0] COND_PL = 4'd5;
  localparam logic [COND_W-1:0] COND_VS = 4'd6;
  localparam logic [COND_W-1:0] COND_VC = 4'd7;
  localparam logic [COND_W-1:0] COND_HI = 4'd8;
  localparam logic [COND_W-1:0] COND_LS = 4'd9;
  localparam logic [COND_W-1:0] COND_GE = 4'd10;
  localparam logic [COND_W-1:0] COND_LT = 4'd11;
  localparam logic [COND_W-1:0] COND_GT = 4'd12;
  localparam logic [COND_W-1:0] COND_LE = 4'd13;
  localparam logic [COND_W-1:0] COND_AL = 4'd14;
  localparam logic [COND_W-1:0] COND_NV = 4'd15;

  // {N,Z,C,V,M} all set means the processor has halted
  localparam logic [FLAG_W-1:0] HALT_PATTERN = 5'h1f;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic is_halt(input logic [FLAG_W-1:0] flags);
    return flags == HALT_PATTERN;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: cond + N/Z/C/V -> taken.
module cond_eval
  import branch_cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  nzcv_t             flags,
  output logic              taken_c
);

  logic n_eq_v;

  assign n_eq_v = (flags.n == flags.v);

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_EQ: taken_c = flags.z;
      COND_NE: taken_c = !flags.z;
      COND_CS: taken_c = flags.c;
      COND_CC: taken_c = !flags.c;
      COND_MI: taken_c = flags.n;
      COND_PL: taken_c = !flags.n;
      COND_VS: taken_c = flags.v;
      COND_VC: taken_c = !flags.v;
      COND_HI: taken_c = flags.c && !flags.z;
      COND_LS: taken_c = !flags.c || flags.z;
      COND_GE: taken_c = n_eq_v;
      COND_LT: taken_c = !n_eq_v;
      COND_GT: taken_c = !flags.z && n_eq_v;
      COND_LE: taken_c = flags.z || !n_eq_v;
      COND_AL: taken_c = 1'b1;
      COND_NV: taken_c = 1'b0;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: evaluates a condition code against the status flags,
// deferring one edge when the flag register is being rewritten, and holds the decision.
module branch_cond_unit
  import branch_cond_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              negative_flag,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              overflow_flag,
  input  logic              mode_flag,
  input  logic [UPD_W-1:0]  update_mode,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COND_W-1:0] req_cond,
  input  logic [ADDR_W-1:0] req_target,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [COND_W-1:0]   cond_q;
  logic [ADDR_W-1:0]   target_q;
  logic                res_valid_q;
  logic                res_taken_q;
  logic [ADDR_W-1:0]   res_target_q;
  logic                halted_q;
  logic [CNT_W-1:0]    taken_count_q;

  nzcv_t               flags_c;
  logic [FLAG_W-1:0]   all_flags_c;
  logic [COND_W-1:0]   eval_cond_c;
  logic                eval_taken_c;
  logic                accept_c;
  logic                retire_c;
  logic                capture_req_c;
  logic                load_res_c;
  logic [ADDR_W-1:0]   res_target_d;

  assign flags_c     = {negative_flag, zero_flag, carry_flag, overflow_flag};
  assign all_flags_c = {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag};

  // A deferred request is re-evaluated from its latched condition with the fresh flags
  assign eval_cond_c = (state_q == WAIT) ? cond_q : req_cond;

  cond_eval u_cond_eval (
    .cond    (eval_cond_c),
    .flags   (flags_c),
    .taken_c (eval_taken_c)
  );

  assign req_ready = !halted_q && ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
  assign accept_c  = req_valid && req_ready;
  assign retire_c  = (state_q == HOLD) && res_ready;

  // Next state and load strobes
  always_comb begin
    state_d       = state_q;
    capture_req_c = 1'b0;
    load_res_c    = 1'b0;
    res_target_d  = res_target_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept_c) begin
          if (update_mode == '0) begin
            state_d      = HOLD;
            load_res_c   = 1'b1;
            res_target_d = req_target;
          end else begin
            state_d       = WAIT;
            capture_req_c = 1'b1;
          end
        end else if (retire_c) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        state_d      = HOLD;
        load_res_c   = 1'b1;
        res_target_d = target_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request held while the flag register settles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cond_q   <= COND_EQ;
      target_q <= '0;
    end else if (capture_req_c) begin
      cond_q   <= req_cond;
      target_q <= req_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
    end else begin
      res_valid_q <= (state_d == HOLD);
      if (load_res_c) begin
        res_taken_q  <= eval_taken_c;
        res_target_q <= res_target_d;
      end
    end
  end

  // Sticky halt; only reset clears it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else if (is_halt(all_flags_c)) begin
      halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      taken_count_q <= '0;
    end else if (retire_c && res_taken_q && (taken_count_q != CNT_MAX)) begin
      taken_count_q <= taken_count_q + CNT_W'(1);
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_target  = res_target_q;
  assign halted      = halted_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: directed requests push hand-computed
// decisions; a negedge monitor pops and compares on every retirement.
module tb_branch_cond_unit;
  import branch_cond_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag;
  logic [2:0]        update_mode;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cond;
  logic [ADDR_W-1:0] req_target;
  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              halted;
  logic [CNT_W-1:0]  taken_count;

  logic [3:0]        ref_cond;
  nzcv_t             ref_flags;
  logic              ref_taken;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_stall = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  branch_cond_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .negative_flag (negative_flag),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .mode_flag     (mode_flag),
    .update_mode   (update_mode),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cond      (req_cond),
    .req_target    (req_target),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .halted        (halted),
    .taken_count   (taken_count)
  );

  cond_eval ref_eval (
    .cond    (ref_cond),
    .flags   (ref_flags),
    .taken_c (ref_taken)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request until accepted; optionally push its expected decision
  task automatic issue(input logic [3:0] cond, input logic [ADDR_W-1:0] tgt,
                       input logic [2:0] um, input logic exp_taken, input bit push);
    bit ok;
    ok          = 1'b0;
    req_valid   = 1'b1;
    req_cond    = cond;
    req_target  = tgt;
    update_mode = um;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed %0b, expected 1 (target %0h)", req_ready, tgt);
    end else begin
      if (push) exp_q.push_back('{taken: exp_taken, target: tgt});
      @(posedge clock);
      #1;
    end
    req_valid   = 1'b0;
    update_mode = 3'd0;
  endtask

  // Monitor: compare every retired decision and the hold-while-stalled contract
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) check("valid_held_in_stall", 32'(res_valid), 32'd1);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got target %0h, expected no result", res_target);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_taken", 32'(res_taken), 32'(mon_e.taken));
          check("res_target", 32'(res_target), 32'(mon_e.target));
        end
      end
    end
    prev_stall = reset && res_valid && !res_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    reset = 1'b0;
    {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag} = 5'b0;
    update_mode = 3'd0;
    req_valid   = 1'b0;
    req_cond    = 4'd0;
    req_target  = '0;
    res_ready   = 1'b1;
    ref_cond    = 4'd0;
    ref_flags   = '0;

    // Condition table: three flag sets against hand-computed masks (bit i = cond i)
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin ref_flags = 4'b1010; mask = 16'h6996; end
        1: begin ref_flags = 4'b0100; mask = 16'h66A9; end
        default: begin ref_flags = 4'b1001; mask = 16'h565A; end
      endcase
      for (int c = 0; c < 16; c++) begin
        ref_cond = 4'(c);
        #1;
        check($sformatf("cond_table_set%0d_cond%0d", k, c), 32'(ref_taken), 32'(mask[c]));
      end
    end

    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_taken", 32'(res_taken), 32'd0);
    check("reset_res_target", 32'(res_target), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_taken_count", 32'(taken_count), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // EQ with Z=1, quiet flags: one-cycle latency
    zero_flag = 1'b1;
    issue(COND_EQ, 16'h0040, 3'd0, 1'b1, 1'b1);
    @(negedge clock);
    check("eq_latency_valid", 32'(res_valid), 32'd1);
    @(posedge clock); #1;
    check("eq_count", 32'(taken_count), 32'd1);
    check("eq_retired", 32'(res_valid), 32'd0);

    // GT then LT with N=1 V=0 Z=0, back to back
    zero_flag = 1'b0; negative_flag = 1'b1; overflow_flag = 1'b0;
    issue(COND_GT, 16'h0100, 3'd0, 1'b0, 1'b1);
    issue(COND_LT, 16'h0102, 3'd0, 1'b1, 1'b1);
    @(posedge clock); #1;
    check("gt_lt_count", 32'(taken_count), 32'd2);

    // Flag hazard: Z written on the negedge after a deferred accept
    negative_flag = 1'b0; zero_flag = 1'b0;
    issue(COND_EQ, 16'h0200, 3'd2, 1'b1, 1'b1);
    check("hazard_wait_no_valid", 32'(res_valid), 32'd0);
    @(negedge clock);
    zero_flag = 1'b1;
    @(posedge clock); #1;
    check("hazard_valid", 32'(res_valid), 32'd1);
    check("hazard_taken", 32'(res_taken), 32'd1);
    @(posedge clock); #1;
    check("hazard_count", 32'(taken_count), 32'd3);

    // Consumer stall for 5 cycles, then retire and accept together
    zero_flag = 1'b0; carry_flag = 1'b1; res_ready = 1'b0;
    issue(COND_CS, 16'h0300, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_taken", 32'(res_taken), 32'd1);
      check("stall_target", 32'(res_target), 32'h0300);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clock); #1;
    res_ready = 1'b1;
    issue(COND_NE, 16'h0304, 3'd0, 1'b1, 1'b1);
    @(posedge clock); #1;
    check("stall_count", 32'(taken_count), 32'd5);

    // NV never counts
    issue(COND_NV, 16'h0400, 3'd0, 1'b0, 1'b1);
    @(posedge clock); #1;
    check("nv_count", 32'(taken_count), 32'd5);

    // HALT pattern while holding a result
    carry_flag = 1'b0; res_ready = 1'b0;
    issue(COND_AL, 16'h0500, 3'd0, 1'b1, 1'b1);
    {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag} = 5'h1f;
    @(posedge clock); #1;
    {negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag} = 5'h00;
    check("halt_set", 32'(halted), 32'd1);
    check("halt_valid_kept", 32'(res_valid), 32'd1);
    req_valid = 1'b1; req_cond = COND_AL; req_target = 16'h0600; res_ready = 1'b1;
    @(negedge clock);
    check("halt_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    check("halt_retired", 32'(res_valid), 32'd0);
    check("halt_count", 32'(taken_count), 32'd6);
    check("halt_sticky", 32'(halted), 32'd1);
    @(posedge clock); #1;
    check("halt_no_accept", 32'(res_valid), 32'd0);
    check("halt_req_ready_idle", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    check("halt_reset_halted", 32'(halted), 32'd0);
    check("halt_reset_count", 32'(taken_count), 32'd0);
    check("halt_reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Counter saturation at 4'hF
    for (int i = 0; i < 20; i++) begin
      issue(COND_AL, 16'(16'h1000 + i), 3'd0, 1'b1, 1'b1);
      if (i == 14) check("sat_count_14", 32'(taken_count), 32'd14);
    end
    @(posedge clock); #1;
    check("sat_count", 32'(taken_count), 32'hF);

    // Reset pulsed while a request sits in WAIT
    issue(COND_AL, 16'h0700, 3'd3, 1'b1, 1'b0);
    check("wait_no_valid", 32'(res_valid), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("wait_reset_valid", 32'(res_valid), 32'd0);
    check("wait_reset_req_ready", 32'(req_ready), 32'd1);
    check("wait_reset_count", 32'(taken_count), 32'd0);
    check("wait_reset_target", 32'(res_target), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("wait_discarded", 32'(res_valid), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
